// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and ALU-side signals of the shared ALU arbiter
interface alu_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_dataA;
   logic [31:0] req0_dataB;
   logic [5:0]  req0_signal;
   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_dataA;
   logic [31:0] req1_dataB;
   logic [5:0]  req1_signal;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [31:0] alu_dataA;
   logic [31:0] alu_dataB;
   logic [5:0]  alu_signal;
   logic [31:0] alu_dataOut;

   modport slave (
      input  req0_valid, req0_dataA, req0_dataB, req0_signal,
      input  req1_valid, req1_dataA, req1_dataB, req1_signal,
      input  rsp_ready, alu_dataOut,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_data, rsp_err,
      output alu_dataA, alu_dataB, alu_signal
   );

   modport master (
      output req0_valid, req0_dataA, req0_dataB, req0_signal,
      output req1_valid, req1_dataA, req1_dataB, req1_signal,
      output rsp_ready, alu_dataOut,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_data, rsp_err,
      input  alu_dataA, alu_dataB, alu_signal
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-requester sequencer for a shared combinational ALU,
// holding ALU inputs SETTLE cycles before capturing the result.
module alu_arbiter #(
   parameter int SETTLE = 2
) (
   input logic          clk,
   input logic          reset,
   alu_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        last_q, last_d;
   logic        id_q, id_d;
   logic        err_q, err_d;
   logic        bad_q, bad_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [5:0]  sig_q, sig_d;
   logic [31:0] data_q, data_d;
   logic        g0, g1, acc, legal;
   logic [31:0] in_a, in_b;
   logic [5:0]  in_sig;

   // On a tie the requester not granted last wins
   assign g0 = bus.req0_valid && (!bus.req1_valid || last_q);
   assign g1 = bus.req1_valid && (!bus.req0_valid || !last_q);
   assign bus.req0_ready = reset && state_q == IDLE && g0;
   assign bus.req1_ready = reset && state_q == IDLE && g1;
   assign acc = bus.req0_ready || bus.req1_ready;
   assign in_a = g1 ? bus.req1_dataA : bus.req0_dataA;
   assign in_b = g1 ? bus.req1_dataB : bus.req0_dataB;
   assign in_sig = g1 ? bus.req1_signal : bus.req0_signal;
   assign legal = in_sig inside {6'd36, 6'd37, 6'd32, 6'd34, 6'd42};

   // Illegal codes pass one EXEC cycle with ALU inputs untouched and report a zero result
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      last_d = last_q;
      id_d = id_q;
      err_d = err_q;
      bad_d = bad_q;
      a_d = a_q;
      b_d = b_q;
      sig_d = sig_q;
      data_d = data_q;
      if (state_q == IDLE && acc) begin
         id_d = g1;
         last_d = g1;
         bad_d = !legal;
         state_d = EXEC;
         cnt_d = legal ? 4'(SETTLE - 1) : 4'd0;
         a_d = legal ? in_a : a_q;
         b_d = legal ? in_b : b_q;
         sig_d = legal ? in_sig : sig_q;
      end else if (state_q == EXEC) begin
         cnt_d = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
         state_d = cnt_q == 4'd0 ? DONE : EXEC;
         data_d = cnt_q == 4'd0 ? (bad_q ? 32'd0 : bus.alu_dataOut) : data_q;
         err_d = cnt_q == 4'd0 ? bad_q : err_q;
      end else if (state_q == DONE && bus.rsp_ready) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q <= 4'd0;
         last_q <= 1'b1;
         id_q <= 1'b0;
         err_q <= 1'b0;
         bad_q <= 1'b0;
         a_q <= 32'd0;
         b_q <= 32'd0;
         sig_q <= 6'd0;
         data_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         last_q <= last_d;
         id_q <= id_d;
         err_q <= err_d;
         bad_q <= bad_d;
         a_q <= a_d;
         b_q <= b_d;
         sig_q <= sig_d;
         data_q <= data_d;
      end
   end

   assign bus.rsp_valid = state_q == DONE;
   assign bus.rsp_id = id_q;
   assign bus.rsp_data = data_q;
   assign bus.rsp_err = err_q;
   assign bus.alu_dataA = a_q;
   assign bus.alu_dataB = b_q;
   assign bus.alu_signal = sig_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct packed {
      logic        id;
      logic [31:0] data;
      logic        err;
   } rsp_t;
   rsp_t exp_q[$];

   alu_arbiter_if bus();
   alu_arbiter #(.SETTLE(2)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      bus.alu_dataOut = 32'd0;
      case (bus.alu_signal)
         6'd36: bus.alu_dataOut = bus.alu_dataA & bus.alu_dataB;
         6'd37: bus.alu_dataOut = bus.alu_dataA | bus.alu_dataB;
         6'd32: bus.alu_dataOut = bus.alu_dataA + bus.alu_dataB;
         6'd34: bus.alu_dataOut = bus.alu_dataA - bus.alu_dataB;
         6'd42: bus.alu_dataOut = {31'd0, $signed(bus.alu_dataA) < $signed(bus.alu_dataB)};
         default: bus.alu_dataOut = 32'd0;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   initial forever begin
      rsp_t e;
      @(negedge clk);
      #2;
      if (reset && bus.rsp_valid && bus.rsp_ready) begin
         if (exp_q.size() == 0) fail_now("unexpected_response");
         else begin
            e = exp_q.pop_front();
            check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            check("rsp_data", bus.rsp_data, e.data);
            check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
         end
      end
   end

   task automatic drive(input bit port, input bit v, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] sig);
      if (port) begin
         bus.req1_valid = v; bus.req1_dataA = a; bus.req1_dataB = b; bus.req1_signal = sig;
      end else begin
         bus.req0_valid = v; bus.req0_dataA = a; bus.req0_dataB = b; bus.req0_signal = sig;
      end
   endtask

   task automatic issue(input bit port, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] sig, input logic [31:0] exp_data, input bit exp_err,
                        input int exp_lat);
      bit found = 0;
      int n = 0;
      @(negedge clk);
      drive(port, 1'b1, a, b, sig);
      for (int i = 0; i < 40; i++) begin
         #1;
         if (port ? bus.req1_ready : bus.req0_ready) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      if (!found) begin
         fail_now("ready_timeout");
         drive(port, 1'b0, a, b, sig);
         return;
      end
      exp_q.push_back('{id: port, data: exp_data, err: exp_err});
      @(posedge clk);
      #1;
      drive(port, 1'b0, a, b, sig);
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bus.rsp_valid && n < 40);
      check("latency", 32'(n), 32'(exp_lat));
   endtask

   initial begin
      int acc = 0;
      int prev = 0;
      bit seen = 0;
      bus.rsp_ready = 1'b1;
      drive(0, 1'b1, 32'd1, 32'd2, 6'd32);
      drive(1, 1'b1, 32'd3, 32'd4, 6'd32);
      repeat (3) begin
         @(negedge clk);
         #1;
         check("rst_ready0", 32'(bus.req0_ready), 0);
         check("rst_ready1", 32'(bus.req1_ready), 0);
      end
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_rsp_id", 32'(bus.rsp_id), 0);
      check("rst_rsp_err", 32'(bus.rsp_err), 0);
      check("rst_alu_a", bus.alu_dataA, 0);
      check("rst_alu_b", bus.alu_dataB, 0);
      check("rst_alu_sig", 32'(bus.alu_signal), 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("first_grant0", 32'(bus.req0_ready), 1);
      check("first_grant1", 32'(bus.req1_ready), 0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;

      issue(0, 32'd5, 32'd7, 6'd32, 32'h0000000C, 0, 2);
      issue(1, 32'd3, 32'd5, 6'd34, 32'hFFFFFFFE, 0, 2);
      issue(1, 32'hFFFFFFFF, 32'd1, 6'd42, 32'd1, 0, 2);

      @(negedge clk);
      drive(0, 1'b1, 32'd1, 32'd1, 6'd32);
      drive(1, 1'b1, 32'h000000F0, 32'h0000000F, 6'd37);
      for (int k = 0; k < 4; k++)
         exp_q.push_back('{id: k[0], data: k[0] ? 32'hFF : 32'd2, err: 1'b0});
      for (int i = 0; i < 80 && acc < 4; i++) begin
         #1;
         if (bus.req0_ready || bus.req1_ready) begin
            check("alt_grant", 32'(bus.req1_ready), 32'(acc % 2));
            if (acc > 0) check("alt_spacing", 32'(cyc - prev), 4);
            prev = cyc;
            acc++;
         end
         if (acc == 4) begin
            @(posedge clk);
            #1;
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
         end else @(negedge clk);
      end
      if (acc < 4) begin
         fail_now("alt_timeout");
         bus.req0_valid = 1'b0;
         bus.req1_valid = 1'b0;
      end

      issue(0, 32'h12345678, 32'h1, 6'd0, 32'd0, 1, 1);
      check("illegal_alu_sig_kept", 32'(bus.alu_signal), 37);
      check("illegal_alu_a_kept", bus.alu_dataA, 32'h000000F0);
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;

      issue(0, 32'h10, 32'h20, 6'd32, 32'h30, 0, 2);
      @(negedge clk);
      drive(1, 1'b1, 32'd9, 32'd4, 6'd34);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("hold_valid", 32'(bus.rsp_valid), 1);
         check("hold_data", bus.rsp_data, 32'h30);
         check("hold_id", 32'(bus.rsp_id), 0);
         check("hold_ready", 32'(bus.req0_ready | bus.req1_ready), 0);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("post_hold_ready1", 32'(bus.req1_ready), 1);
      @(posedge clk);
      #1;
      bus.req1_valid = 1'b0;
      check("inflight_alu_a", bus.alu_dataA, 32'd9);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_rsp_valid", 32'(bus.rsp_valid), 0);
      check("abort_alu_a", bus.alu_dataA, 0);
      check("abort_alu_sig", 32'(bus.alu_signal), 0);
      check("abort_rsp_data", bus.rsp_data, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         if (bus.rsp_valid) seen = 1;
      end
      check("abort_no_response", 32'(seen), 0);
      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
